// File: rtl/pipe_ctrl_if.sv
// ID/EX control handshake bundle between the pipeline datapath (master) and pipe_ctrl_unit (slave).
// With CTRL_JAL_EN defined, the bundle also carries ex_link.
interface pipe_ctrl_if #(
    parameter int OP_W    = 6,
    parameter int FN_W    = 6,
    parameter int RA_W    = 5,
    parameter int ALUOP_W = 4
);
    logic               id_valid;
    logic [OP_W-1:0]    id_op;
    logic [FN_W-1:0]    id_funct;
    logic [RA_W-1:0]    id_rs;
    logic [RA_W-1:0]    id_rt;
    logic               ex_flush;
    logic               stall;
    logic               ex_valid;
    logic               ex_seldst;
    logic               ex_alusrc;
    logic               ex_memtoreg;
    logic               ex_regwrite;
    logic               ex_memread;
    logic               ex_memwrite;
    logic               ex_branch;
    logic               ex_jump;
    logic [ALUOP_W-1:0] ex_aluop;
    logic [RA_W-1:0]    ex_rt;
    logic               md_busy;
`ifdef CTRL_JAL_EN
    logic               ex_link;
`endif

    modport master (
`ifdef CTRL_JAL_EN
        input  ex_link,
`endif
        output id_valid, id_op, id_funct, id_rs, id_rt, ex_flush,
        input  stall, ex_valid, ex_seldst, ex_alusrc, ex_memtoreg, ex_regwrite,
               ex_memread, ex_memwrite, ex_branch, ex_jump, ex_aluop, ex_rt, md_busy
    );

    modport slave (
`ifdef CTRL_JAL_EN
        output ex_link,
`endif
        input  id_valid, id_op, id_funct, id_rs, id_rt, ex_flush,
        output stall, ex_valid, ex_seldst, ex_alusrc, ex_memtoreg, ex_regwrite,
               ex_memread, ex_memwrite, ex_branch, ex_jump, ex_aluop, ex_rt, md_busy
    );
endinterface

// File: rtl/pipe_ctrl_unit.sv
// Pipelined control unit: ID decode, ID/EX control register, load-use and mult/div stall, flush bubbles.
// Optional macro CTRL_JAL_EN adds jal decode and the registered ex_link output.
module pipe_ctrl_unit #(
    parameter int OP_W    = 6,
    parameter int FN_W    = 6,
    parameter int RA_W    = 5,
    parameter int ALUOP_W = 4,
    parameter int MD_LAT  = 4
) (
    input logic          clk,
    input logic          rst,
    pipe_ctrl_if.slave   bus
);
    localparam logic [OP_W-1:0] OP_R   = OP_W'(6'b000000);
    localparam logic [OP_W-1:0] OP_LW  = OP_W'(6'b100011);
    localparam logic [OP_W-1:0] OP_SW  = OP_W'(6'b101011);
    localparam logic [OP_W-1:0] OP_BEQ = OP_W'(6'b000100);
    localparam logic [OP_W-1:0] OP_J   = OP_W'(6'b000010);
`ifdef CTRL_JAL_EN
    localparam logic [OP_W-1:0] OP_JAL = OP_W'(6'b000011);
`endif
    localparam logic [FN_W-1:0] FN_MULT  = FN_W'(6'b011000);
    localparam logic [FN_W-1:0] FN_MULTU = FN_W'(6'b011001);
    localparam logic [FN_W-1:0] FN_DIV   = FN_W'(6'b011010);
    localparam logic [FN_W-1:0] FN_DIVU  = FN_W'(6'b011011);

    localparam int              CNT_W   = (MD_LAT > 1) ? $clog2(MD_LAT) : 1;
    localparam logic [CNT_W-1:0] MD_LOAD = CNT_W'(MD_LAT - 1);

    // Control vector bit order: {seldst, alusrc, memtoreg, regwrite, memread, memwrite, branch, jump}
    logic [7:0]         ctl_d;
    logic [ALUOP_W-1:0] aluop_d;
    logic               uses_rt;
    logic               is_md;
    logic               load_use;
    logic               stall_c;

    logic [7:0]         ctl_p1;
    logic [ALUOP_W-1:0] aluop_p1;
    logic [RA_W-1:0]    rt_p1;
    logic               vld_p1;
    logic [CNT_W-1:0]   md_cnt;
`ifdef CTRL_JAL_EN
    logic               link_d;
    logic               link_p1;
`endif

    always_comb begin
        ctl_d   = 8'b0000_0000;
        aluop_d = '0;
`ifdef CTRL_JAL_EN
        link_d  = 1'b0;
`endif
        case (bus.id_op)
            OP_R:   begin ctl_d = 8'b1001_0000; aluop_d = ALUOP_W'(4'b0000); end
            OP_LW:  begin ctl_d = 8'b0111_1000; aluop_d = ALUOP_W'(4'b0011); end
            OP_SW:  begin ctl_d = 8'b0100_0100; aluop_d = ALUOP_W'(4'b1011); end
            OP_BEQ: begin ctl_d = 8'b0000_0010; aluop_d = ALUOP_W'(4'b0100); end
            OP_J:   begin ctl_d = 8'b0000_0001; aluop_d = ALUOP_W'(4'b0010); end
`ifdef CTRL_JAL_EN
            OP_JAL: begin ctl_d = 8'b0001_0001; aluop_d = ALUOP_W'(4'b0010); link_d = 1'b1; end
`endif
            default: ;
        endcase
    end

    assign uses_rt = (bus.id_op == OP_R) || (bus.id_op == OP_SW) || (bus.id_op == OP_BEQ);
    assign is_md   = (bus.id_op == OP_R) &&
                     (bus.id_funct inside {FN_MULT, FN_MULTU, FN_DIV, FN_DIVU});

    // A load in EX whose destination is read by the ID instruction must wait one cycle;
    // $0 never carries a real dependency.
    assign load_use = bus.id_valid && vld_p1 && ctl_p1[3] && (rt_p1 != '0) &&
                      ((rt_p1 == bus.id_rs) || (uses_rt && (rt_p1 == bus.id_rt)));
    assign stall_c  = (load_use || (md_cnt != '0)) && !bus.ex_flush;

    // ID -> EX boundary
    always_ff @(posedge clk) begin
        if (rst || bus.ex_flush) begin
            ctl_p1   <= '0;
            aluop_p1 <= '0;
            rt_p1    <= '0;
            vld_p1   <= 1'b0;
            md_cnt   <= '0;
`ifdef CTRL_JAL_EN
            link_p1  <= 1'b0;
`endif
        end else if (stall_c) begin
            ctl_p1   <= '0;
            aluop_p1 <= '0;
            rt_p1    <= '0;
            vld_p1   <= 1'b0;
            if (md_cnt != '0) md_cnt <= md_cnt - 1'b1;
`ifdef CTRL_JAL_EN
            link_p1  <= 1'b0;
`endif
        end else begin
            vld_p1   <= bus.id_valid;
            ctl_p1   <= bus.id_valid ? ctl_d : 8'b0000_0000;
            aluop_p1 <= bus.id_valid ? aluop_d : '0;
            rt_p1    <= bus.id_valid ? bus.id_rt : '0;
`ifdef CTRL_JAL_EN
            link_p1  <= bus.id_valid && link_d;
`endif
            if (bus.id_valid && is_md) md_cnt <= MD_LOAD;
            else if (md_cnt != '0)     md_cnt <= md_cnt - 1'b1;
        end
    end

    assign bus.stall       = stall_c;
    assign bus.md_busy     = (md_cnt != '0);
    assign bus.ex_valid    = vld_p1;
    assign bus.ex_seldst   = ctl_p1[7];
    assign bus.ex_alusrc   = ctl_p1[6];
    assign bus.ex_memtoreg = ctl_p1[5];
    assign bus.ex_regwrite = ctl_p1[4];
    assign bus.ex_memread  = ctl_p1[3];
    assign bus.ex_memwrite = ctl_p1[2];
    assign bus.ex_branch   = ctl_p1[1];
    assign bus.ex_jump     = ctl_p1[0];
    assign bus.ex_aluop    = aluop_p1;
    assign bus.ex_rt       = rt_p1;
`ifdef CTRL_JAL_EN
    assign bus.ex_link     = link_p1;
`endif
endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Randomized bench for pipe_ctrl_unit against a behavioural model of the EX stage and mult/div occupancy.
// Honours CTRL_JAL_EN when the design is built with it.
module tb_pipe_ctrl_unit;
    localparam int MD_LAT = 4;
    localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011,
                           BEQ = 6'b000100, J = 6'b000010, JAL = 6'b000011, ADDI = 6'b001000;

    typedef struct packed {
        logic       valid;
        logic       seldst, alusrc, memtoreg, regwrite, memread, memwrite, branch, jump, link;
        logic [3:0] aluop;
        logic [4:0] rt;
    } ex_t;

    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_pass = 0;
    ex_t  m;
    int   cyc;
    int   busy_until;

    always #5 clk = ~clk;

    pipe_ctrl_if #(.OP_W(6), .FN_W(6), .RA_W(5), .ALUOP_W(4)) bus ();

    pipe_ctrl_unit #(.OP_W(6), .FN_W(6), .RA_W(5), .ALUOP_W(4), .MD_LAT(MD_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // What an instruction means, straight from the opcode table.
    function automatic ex_t meaning(input logic [5:0] op, input logic [4:0] rt);
        ex_t e = '0;
        e.valid = 1'b1;
        e.rt    = rt;
        if (op == R)       begin e.seldst = 1; e.regwrite = 1; e.aluop = 4'b0000; end
        else if (op == LW) begin e.alusrc = 1; e.memtoreg = 1; e.regwrite = 1; e.memread = 1; e.aluop = 4'b0011; end
        else if (op == SW) begin e.alusrc = 1; e.memwrite = 1; e.aluop = 4'b1011; end
        else if (op == BEQ) begin e.branch = 1; e.aluop = 4'b0100; end
        else if (op == J)  begin e.jump = 1; e.aluop = 4'b0010; end
`ifdef CTRL_JAL_EN
        else if (op == JAL) begin e.jump = 1; e.regwrite = 1; e.link = 1; e.aluop = 4'b0010; end
`endif
        return e;
    endfunction

    function automatic logic exp_stall(input logic v, input logic [5:0] op, input logic [4:0] rs, rt,
                                       input logic f);
        logic reads_rt = (op == R) || (op == SW) || (op == BEQ);
        logic lu = v && m.valid && m.memread && (m.rt != 0) &&
                   ((m.rt == rs) || (reads_rt && (m.rt == rt)));
        return (lu || (cyc < busy_until)) && !f;
    endfunction

    task automatic step(input logic r, f, v, input logic [5:0] op, fn, input logic [4:0] rs, rt);
        logic s;
        @(negedge clk);
        chk("ex_valid", 32'(bus.ex_valid), 32'(m.valid));
        chk("ex_ctl", 32'({bus.ex_seldst, bus.ex_alusrc, bus.ex_memtoreg, bus.ex_regwrite,
                           bus.ex_memread, bus.ex_memwrite, bus.ex_branch, bus.ex_jump}),
                      32'({m.seldst, m.alusrc, m.memtoreg, m.regwrite,
                           m.memread, m.memwrite, m.branch, m.jump}));
        chk("ex_aluop", 32'(bus.ex_aluop), 32'(m.aluop));
        chk("ex_rt", 32'(bus.ex_rt), 32'(m.rt));
        chk("md_busy", 32'(bus.md_busy), 32'(cyc < busy_until));
`ifdef CTRL_JAL_EN
        chk("ex_link", 32'(bus.ex_link), 32'(m.link));
`endif
        rst          = r;
        bus.ex_flush = f;
        bus.id_valid = v;
        bus.id_op    = op;
        bus.id_funct = fn;
        bus.id_rs    = rs;
        bus.id_rt    = rt;
        #1;
        s = exp_stall(v, op, rs, rt, f);
        chk("stall", 32'(bus.stall), 32'(s));
        @(posedge clk);
        cyc++;
        if (r || f) begin
            m = '0;
            busy_until = 0;
        end else if (s || !v) begin
            m = '0;
        end else begin
            m = meaning(op, rt);
            if (op == R && fn inside {6'b011000, 6'b011001, 6'b011010, 6'b011011})
                busy_until = cyc + MD_LAT - 1;
        end
    endtask

    logic [5:0] op_tab [7];

    initial begin
        op_tab = '{R, LW, SW, BEQ, J, JAL, ADDI};
        rst = 1'b1;
        bus.ex_flush = 1'b0; bus.id_valid = 1'b1; bus.id_op = LW;
        bus.id_funct = 6'h00; bus.id_rs = 5'd0; bus.id_rt = 5'd5;
        @(posedge clk);
        m = '0; cyc = 0; busy_until = 0;

        // reset held with a valid load in ID
        step(1, 0, 1, LW, 6'h00, 5'd0, 5'd5);
        step(1, 0, 1, LW, 6'h00, 5'd0, 5'd5);
        // load-use via rs: one stall, then R latched
        step(0, 0, 1, LW, 6'h00, 5'd0, 5'd5);
        step(0, 0, 1, R,  6'h20, 5'd5, 5'd1);
        step(0, 0, 1, R,  6'h20, 5'd5, 5'd1);
        // $0 destination never stalls
        step(0, 0, 1, LW, 6'h00, 5'd0, 5'd0);
        step(0, 0, 1, R,  6'h20, 5'd0, 5'd0);
        // sw reading the loaded register through rt
        step(0, 0, 1, LW, 6'h00, 5'd0, 5'd5);
        step(0, 0, 1, SW, 6'h00, 5'd1, 5'd5);
        step(0, 0, 1, SW, 6'h00, 5'd1, 5'd5);
        // MULT occupies EX for MD_LAT cycles
        step(0, 0, 1, R,  6'b011000, 5'd2, 5'd3);
        for (int i = 0; i < 5; i++) step(0, 0, 1, ADDI, 6'h00, 5'd1, 5'd2);
        // flush during a load-use stall
        step(0, 0, 1, LW, 6'h00, 5'd0, 5'd7);
        step(0, 1, 1, R,  6'h20, 5'd7, 5'd1);
        // flush during mult/div, reset during mult/div
        step(0, 0, 1, R,  6'b011010, 5'd2, 5'd3);
        step(0, 0, 1, R,  6'h20, 5'd1, 5'd1);
        step(0, 1, 1, R,  6'h20, 5'd1, 5'd1);
        step(0, 0, 1, R,  6'b011011, 5'd2, 5'd3);
        step(1, 0, 1, R,  6'h20, 5'd1, 5'd1);
        // jumps
        step(0, 0, 1, J,   6'h00, 5'd0, 5'd0);
        step(0, 0, 1, JAL, 6'h00, 5'd0, 5'd0);
        step(0, 0, 0, R,   6'h00, 5'd0, 5'd0);

        for (int i = 0; i < 3000; i++) begin
            logic [5:0] fn;
            fn = ($urandom_range(0, 99) < 25) ? (6'b011000 | 6'($urandom_range(0, 3)))
                                               : 6'($urandom);
            step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 8,
                 $urandom_range(0, 99) < 85, op_tab[$urandom_range(0, 6)], fn,
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
        end
        step(0, 0, 0, R, 6'h00, 5'd0, 5'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
